divide: RTL and testbench

DIVIDE -- requirements
Module: divide

---
 rtl/divide.sv | 142 ++++++++++++++
 tb/tb_divide.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/divide.sv
// Sign-magnitude fixed-point restoring divider: one quotient bit per clock,
// MSB first, with saturation on overflow and a dedicated divide-by-zero path.
module divide #(
  parameter int WIDTH = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:0] dividend,
  input  logic [WIDTH:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] quotient,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int F  = WIDTH / 2 + 1;
  localparam int N  = WIDTH + F;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] F_CNT    = CW'(F);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_sign;
  logic [N-1:0]       r_num;
  logic [WIDTH-1:0]   r_den;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_ovf;
  logic [CW-1:0]      r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH:0]     r_quotient;
  logic               r_overflow;
  logic               r_div_by_zero;

  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic               w_ovf_next;

  // Remainder never exceeds twice the divisor, so one extra bit holds the trial.
  assign w_trial    = {r_rem, r_num[N-1]};
  assign w_diff     = w_trial - {1'b0, r_den};
  assign w_qbit     = (w_trial >= {1'b0, r_den});
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
  // The first F iterations produce bits of weight 2^WIDTH and above.
  assign w_ovf_next = r_ovf | (w_qbit & (r_cnt < F_CNT));

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;

  // Handshake FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sign        <= 1'b0;
      r_num         <= '0;
      r_den         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_ovf         <= 1'b0;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign     <= dividend[WIDTH] ^ divisor[WIDTH];
            r_num      <= {dividend[WIDTH-1:0], {F{1'b0}}};
            r_den      <= divisor[WIDTH-1:0];
            r_rem      <= '0;
            r_quo      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (divisor[WIDTH-1:0] == '0) begin
              r_state       <= S_DONE;
              r_out_valid   <= 1'b1;
              r_quotient    <= {dividend[WIDTH] ^ divisor[WIDTH], {WIDTH{1'b1}}};
              r_overflow    <= 1'b0;
              r_div_by_zero <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_num <= {r_num[N-2:0], 1'b0};
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_ovf <= w_ovf_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_state       <= S_DONE;
            r_out_valid   <= 1'b1;
            r_quotient    <= {r_sign, (w_ovf_next ? {WIDTH{1'b1}} : w_quo_next)};
            r_overflow    <= w_ovf_next;
            r_div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_quotient    <= '0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_in_ready    <= 1'b1;
          r_out_valid   <= 1'b0;
          r_quotient    <= '0;
          r_overflow    <= 1'b0;
          r_div_by_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for divide: directed vector table, randomized ops against
// an arithmetic reference model, plus hold, reset-abort and ignored-input sequences.
module tb_divide;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  divide #(.WIDTH(31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: exact integer arithmetic on magnitudes, then saturate.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic ovf, output logic dbz);
    logic [63:0] num, qq;
    logic        s;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'd0) begin
      q = {s, 31'h7FFFFFFF}; ovf = 1'b0; dbz = 1'b1;
    end else begin
      num = {33'd0, a[30:0]} * 64'd65536;
      qq  = num / {33'd0, b[30:0]};
      dbz = 1'b0;
      if (qq > 64'h7FFFFFFF) begin
        q = {s, 31'h7FFFFFFF}; ovf = 1'b1;
      end else begin
        q = {s, qq[30:0]}; ovf = 1'b0;
      end
    end
  endfunction

  // Present operands; latency counts edges from presentation, accept edge included.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    in_valid = 1'b1; dividend = a; divisor = b; out_ready = 1'b0;
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      dividend  = $urandom;
      divisor   = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      check("in_ready_busy", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop_out_valid", {63'd0, out_valid}, 64'd0);
    check("pop_in_ready", {63'd0, in_ready}, 64'd1);
    check("pop_outputs_zero", {31'd0, quotient, overflow, div_by_zero}, 64'd0);
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic eo, input logic ed, input int el);
    int lat;
    start_op(a, b, lat);
    check({name, "_lat"}, 64'(lat), 64'(el));
    check({name, "_q"}, {32'd0, quotient}, {32'd0, eq});
    check({name, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
    check({name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ed});
    pop_result();
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] mq, hq;
    logic        mo, md, ho, hd;
    int          lat;
    int          seen;

    // Normal ops: accept edge + 47 iterations = 48 edges; divide-by-zero: 1 edge.
    vecs[0] = '{32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0, 48};
    vecs[1] = '{32'h80010000, 32'h00040000, 32'h80004000, 1'b0, 1'b0, 48};
    vecs[2] = '{32'h00010000, 32'h00030000, 32'h00005555, 1'b0, 1'b0, 48};
    vecs[3] = '{32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 48};
    vecs[4] = '{32'h80010000, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1};
    vecs[6] = '{32'h80030000, 32'h80020000, 32'h00018000, 1'b0, 1'b0, 48};
    vecs[7] = '{32'h3FFF8000, 32'h00008000, 32'h7FFF0000, 1'b0, 1'b0, 48};
    vecs[8] = '{32'h40000000, 32'h80008000, 32'hFFFFFFFF, 1'b1, 1'b0, 48};
    vecs[9] = '{32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b0, 48};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_outputs", {31'd0, quotient, overflow, div_by_zero}, 64'd0);
    rst = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 10; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].ovf, vecs[i].dbz, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 0) b[30:0] = 31'd0;
      model(a, b, mq, mo, md);
      run_and_check($sformatf("rnd%0d", i), a, b, mq, mo, md, (md ? 1 : 48));
    end

    // Result held while the consumer stalls; in_valid during DONE is ignored.
    start_op(32'h00050000, 32'h00020000, lat);
    check("hold_lat", 64'(lat), 64'd48);
    hq = quotient; ho = overflow; hd = div_by_zero;
    check("hold_q_initial", {32'd0, hq}, 64'h00028000);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_outputs", {31'd0, quotient, overflow, div_by_zero}, {31'd0, hq, ho, hd});
    end
    in_valid = 1'b0;
    pop_result();
    run_and_check("after_hold", 32'h00060000, 32'h00030000, 32'h00020000, 1'b0, 1'b0, 48);

    // Reset mid-iteration discards the operation.
    in_valid = 1'b1; dividend = 32'h00030000; divisor = 32'h00020000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_outputs", {31'd0, quotient, overflow, div_by_zero}, 64'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_stale", 64'(seen), 64'd0);
    run_and_check("after_abort", 32'h80010000, 32'h00030000, 32'h80005555, 1'b0, 1'b0, 48);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
